// File: rtl/goose_uart_rx.sv
// goose_uart_rx: 8N1 UART receiver with a one-byte valid/ready buffer.
// Define GOOSE_UART_PARITY_EN for 8E1 frames with parity checking.
module goose_uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef GOOSE_UART_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [CW-1:0]          cnt, cnt_n;
  logic [2:0]             bidx, bidx_n;
  logic [7:0]             shreg, shreg_n;
  logic                   done;
  logic                   fe;
  logic                   good;
  logic                   take;
  logic                   drain;

`ifdef GOOSE_UART_PARITY_EN
  logic par_bad, par_bad_n;
  logic perr_q;
  assign good       = done & ~par_bad;
  assign parity_err = perr_q;
`else
  assign good       = done;
  assign parity_err = 1'b0;
`endif

  assign rx_s  = sync[SYNC_STAGES-1];
  assign busy  = (state != IDLE);
  assign drain = rx_valid & rx_ready;
  assign take  = good & (~rx_valid | rx_ready);

  always_comb begin
    state_n = state;
    cnt_n   = cnt + ONE;
    bidx_n  = bidx;
    shreg_n = shreg;
    done    = 1'b0;
    fe      = 1'b0;
`ifdef GOOSE_UART_PARITY_EN
    par_bad_n = par_bad;
`endif
    unique case (state)
      IDLE: begin
        cnt_n  = '0;
        bidx_n = '0;
`ifdef GOOSE_UART_PARITY_EN
        par_bad_n = 1'b0;
`endif
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          bidx_n  = bidx + 3'd1;
          if (bidx == 3'd7) begin
`ifdef GOOSE_UART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef GOOSE_UART_PARITY_EN
      PARITY: begin
        if (cnt == FULL) begin
          cnt_n     = '0;
          par_bad_n = rx_s ^ (^shreg);
          state_n   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == FULL) begin
          cnt_n = '0;
          if (rx_s) begin
            done    = 1'b1;
            state_n = IDLE;
          end else begin
            fe      = 1'b1;
            state_n = BRK;
          end
        end
      end
      BRK: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= '1;
      state     <= IDLE;
      cnt       <= '0;
      bidx      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef GOOSE_UART_PARITY_EN
      par_bad   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], rx};
      state     <= state_n;
      cnt       <= cnt_n;
      bidx      <= bidx_n;
      shreg     <= shreg_n;
      frame_err <= fe;
      overrun   <= good & rx_valid & ~rx_ready;
`ifdef GOOSE_UART_PARITY_EN
      par_bad   <= par_bad_n;
      perr_q    <= done & par_bad;
`endif
      // a commit landing on a consume keeps rx_valid high
      if (take) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (drain) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
